// File: rtl/spi_regfile_pkg.sv
// Shared opcodes, FSM state encoding and decode helper for the SPI register file.
package spi_regfile_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_READ      = 8'h02;
  localparam logic [7:0] OP_FLAG_MASK = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR,
    ST_DATA,
    ST_SKIP
  } state_t;

  // Flag opcodes are 0b11v_iiiii: top two bits set, v = value, i = flag index.
  function automatic logic is_flag_op(input logic [7:0] op);
    return (op & OP_FLAG_MASK) == OP_FLAG_MASK;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Bit counter plus RX/TX byte shifters for the SPI slave; all state on posedge SCLK.
module spi_byte_shifter
  import spi_regfile_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ss,
  input  logic       i_mosi,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  output logic       o_byte_done,
  output logic       o_partial,
  output logic [7:0] o_rx_byte,
  output logic       o_miso
);

  logic [2:0] r_cnt;
  logic [6:0] r_rx;
  logic [6:0] r_tx;
  logic       r_miso;

  // The byte completes on the 8th selected edge; the incoming bit is the LSB.
  assign o_byte_done = !i_ss && (r_cnt == 3'd7);
  assign o_partial   = (r_cnt != 3'd0);
  assign o_rx_byte   = {r_rx, i_mosi};
  assign o_miso      = r_miso;

  // Shift in MOSI, shift out TX (bit7 goes straight to MISO on a load); deselect clears all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_rx   <= '0;
      r_tx   <= '0;
      r_miso <= 1'b0;
    end else if (i_ss) begin
      r_cnt  <= '0;
      r_rx   <= '0;
      r_tx   <= '0;
      r_miso <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
      r_rx  <= {r_rx[5:0], i_mosi};
      if (i_load) begin
        r_miso <= i_load_data[7];
        r_tx   <= i_load_data[6:0];
      end else begin
        r_miso <= r_tx[6];
        r_tx   <= {r_tx[5:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_regfile_burst.sv
// SPI-slave register file with burst read/write, auto-increment pointer and ready flags.
module spi_regfile_burst
  import spi_regfile_pkg::*;
#(
  parameter int DEPTH      = 162,
  parameter int ADDR_BYTES = 2,
  parameter int NUM_FLAGS  = 3,
  parameter int WRAP       = 1
) (
  input  logic                 SCLK,
  input  logic                 RESET_N,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [NUM_FLAGS-1:0] ready_flags,
  output logic [DEPTH*8-1:0]   all_data_out,
  output logic                 frame_error
);

  localparam int AW = ADDR_BYTES * 8;
  // One extra pointer bit so WRAP=0 can park the pointer at DEPTH even for a full address space.
  localparam int PW = AW + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [1:0]    LAST_AB = 2'(ADDR_BYTES - 1);

  logic          w_byte_done;
  logic          w_partial;
  logic [7:0]    w_rx_byte;
  logic          w_load;
  logic [7:0]    w_load_data;
  logic [PW-1:0] w_load_ptr;
  logic [AW-1:0] w_addr_next;
  logic [PW-1:0] w_addr_ptr;
  logic          w_last_ab;

  state_t        r_state;
  logic [1:0]    r_abyte;
  logic [AW-1:0] r_addr;
  logic [PW-1:0] r_ptr;
  logic          r_rd;
  logic [7:0]    r_mem [DEPTH];
  logic [NUM_FLAGS-1:0] r_flags;
  logic          r_ferr;

  // Burst increment: wrap or park at DEPTH at the top; an out-of-range pointer stays put.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_P)        return (WRAP != 0) ? '0 : DEPTH_P;
    else if (p >= DEPTH_P)  return p;
    else                    return p + PW'(1);
  endfunction

  spi_byte_shifter u_shift (
    .i_clk       (SCLK),
    .i_rst_n     (RESET_N),
    .i_ss        (SS),
    .i_mosi      (MOSI),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .o_byte_done (w_byte_done),
    .o_partial   (w_partial),
    .o_rx_byte   (w_rx_byte),
    .o_miso      (MISO)
  );

  assign w_addr_next = AW'({r_addr, w_rx_byte});
  assign w_addr_ptr  = PW'(w_addr_next);
  assign w_last_ab   = (r_abyte == LAST_AB);

  // Pick the register feeding the TX shifter: the fresh address on the last address byte, else the pointer.
  always_comb begin
    w_load     = 1'b0;
    w_load_ptr = r_ptr;
    if (w_byte_done && r_rd) begin
      if (r_state == ST_ADDR && w_last_ab) begin
        w_load     = 1'b1;
        w_load_ptr = w_addr_ptr;
      end else if (r_state == ST_DATA) begin
        w_load = 1'b1;
      end
    end
    w_load_data = (w_load_ptr < DEPTH_P) ? r_mem[w_load_ptr[IW-1:0]] : 8'h00;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_img
    assign all_data_out[8*g +: 8] = r_mem[g];
  end

  assign ready_flags = r_flags;
  assign frame_error = r_ferr;

  // Frame FSM: opcode decode, address assembly, pointer walk, register writes and flag updates.
  always_ff @(posedge SCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_abyte <= '0;
      r_addr  <= '0;
      r_ptr   <= '0;
      r_rd    <= 1'b0;
      r_flags <= '0;
      r_ferr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (SS) begin
      r_state <= ST_IDLE;
      r_abyte <= '0;
      if (w_partial) r_ferr <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_INSTR;
        ST_INSTR: begin
          if (w_byte_done) begin
            r_abyte <= '0;
            if (w_rx_byte == OP_WRITE || w_rx_byte == OP_READ) begin
              r_state <= ST_ADDR;
              r_rd    <= (w_rx_byte == OP_READ);
              r_ferr  <= 1'b0;
            end else if (is_flag_op(w_rx_byte)) begin
              r_state <= ST_SKIP;
              r_ferr  <= 1'b0;
              for (int k = 0; k < NUM_FLAGS; k++)
                if (w_rx_byte[4:0] == 5'(k)) r_flags[k] <= w_rx_byte[5];
            end else begin
              r_state <= ST_SKIP;
            end
          end
        end
        ST_ADDR: begin
          if (w_byte_done) begin
            r_addr <= w_addr_next;
            if (w_last_ab) begin
              r_state <= ST_DATA;
              r_ptr   <= r_rd ? next_ptr(w_addr_ptr) : w_addr_ptr;
            end else begin
              r_abyte <= r_abyte + 2'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            if (!r_rd && r_ptr < DEPTH_P) r_mem[r_ptr[IW-1:0]] <= w_rx_byte;
            r_ptr <= next_ptr(r_ptr);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regfile_burst.sv
// Bench for spi_regfile_burst: WRAP=1 and WRAP=0 instances share one SPI bus and one reference model.
module tb_spi_regfile_burst;

  localparam int DEPTH = 162;
  localparam int NF    = 3;

  logic SCLK = 1'b0;
  logic RESET_N = 1'b0;
  logic SS = 1'b1;
  logic MOSI = 1'b0;
  logic miso1, miso0;
  logic [NF-1:0] flags1, flags0;
  logic [DEPTH*8-1:0] img1, img0;
  logic ferr1, ferr0;

  spi_regfile_burst #(.DEPTH(DEPTH), .ADDR_BYTES(2), .NUM_FLAGS(NF), .WRAP(1)) dut1 (
    .SCLK(SCLK), .RESET_N(RESET_N), .SS(SS), .MOSI(MOSI), .MISO(miso1),
    .ready_flags(flags1), .all_data_out(img1), .frame_error(ferr1)
  );

  spi_regfile_burst #(.DEPTH(DEPTH), .ADDR_BYTES(2), .NUM_FLAGS(NF), .WRAP(0)) dut0 (
    .SCLK(SCLK), .RESET_N(RESET_N), .SS(SS), .MOSI(MOSI), .MISO(miso0),
    .ready_flags(flags0), .all_data_out(img0), .frame_error(ferr0)
  );

  always #5 SCLK = ~SCLK;

  int nassert = 0;
  int nfail   = 0;

  // Reference state: index 1 models WRAP=1, index 0 models WRAP=0.
  logic [7:0]    mm [2][DEPTH];
  logic [NF-1:0] flg;
  logic          ferr;
  logic [7:0]    fr  [8];
  logic [7:0]    got [2][8];
  logic [7:0]    em  [2][8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_img(input string tag, input int w);
    logic [DEPTH*8-1:0] obs, exp;
    int bad;
    obs = (w == 1) ? img1 : img0;
    bad = -1;
    for (int i = 0; i < DEPTH; i++) begin
      exp[8*i +: 8] = mm[w][i];
      if (bad < 0 && obs[8*i +: 8] !== mm[w][i]) bad = i;
    end
    if (bad < 0) bad = 0;
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: reg %0d observed %0h expected %0h", tag, bad, obs[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++) mm[w][i] = 8'h00;
    flg  = '0;
    ferr = 1'b0;
  endtask

  function automatic int nxt(input int p, input int w);
    if (p == DEPTH - 1) return (w != 0) ? 0 : DEPTH;
    if (p >= DEPTH) return p;
    return p + 1;
  endfunction

  // Apply a frame of n complete bytes (plus an optional unfinished byte) to the model.
  task automatic model_frame(input int n, input bit partial);
    logic [7:0] op;
    int p;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 8; k++) em[w][k] = 8'h00;
    if (n >= 1) begin
      op = fr[0];
      if (op == 8'h01 || op == 8'h02 || op[7:6] == 2'b11) ferr = 1'b0;
      if (op[7:6] == 2'b11)
        for (int j = 0; j < NF; j++)
          if (int'(op[4:0]) == j) flg[j] = op[5];
      if ((op == 8'h01 || op == 8'h02) && n >= 3) begin
        for (int w = 0; w < 2; w++) begin
          p = int'({fr[1], fr[2]});
          for (int k = 3; k < n; k++) begin
            if (op == 8'h01) begin
              if (p < DEPTH) mm[w][p] = fr[k];
            end else begin
              em[w][k] = (p < DEPTH) ? mm[w][p] : 8'h00;
            end
            p = nxt(p, w);
          end
        end
      end
    end
    if (partial) ferr = 1'b1;
  endtask

  task automatic drive_frame(input int n, input int tail);
    int nb;
    for (int k = 0; k < 8; k++) begin
      got[0][k] = 8'h00;
      got[1][k] = 8'h00;
    end
    for (int k = 0; k <= n; k++) begin
      nb = (k < n) ? 8 : tail;
      for (int i = 7; i > 7 - nb; i--) begin
        @(negedge SCLK);
        got[1][k][i] = miso1;
        got[0][k][i] = miso0;
        SS   = 1'b0;
        MOSI = fr[k][i];
      end
    end
    @(negedge SCLK);
    SS   = 1'b1;
    MOSI = 1'b0;
    @(negedge SCLK);
  endtask

  task automatic check_outputs(input string tag, input int n);
    check_img({tag, " img wrap1"}, 1);
    check_img({tag, " img wrap0"}, 0);
    check({tag, " flags wrap1"}, 32'(flags1), 32'(flg));
    check({tag, " flags wrap0"}, 32'(flags0), 32'(flg));
    check({tag, " ferr wrap1"}, 32'(ferr1), 32'(ferr));
    check({tag, " ferr wrap0"}, 32'(ferr0), 32'(ferr));
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s miso wrap1 byte%0d", tag, k), 32'(got[1][k]), 32'(em[1][k]));
      check($sformatf("%s miso wrap0 byte%0d", tag, k), 32'(got[0][k]), 32'(em[0][k]));
    end
  endtask

  task automatic frame(input string tag, input int n, input int tail);
    drive_frame(n, tail);
    model_frame(n, tail != 0);
    check_outputs(tag, n);
  endtask

  initial begin
    int len, addr, sel;
    model_reset();
    repeat (3) @(negedge SCLK);
    check_outputs("reset", 0);
    check("reset miso wrap1", 32'(miso1), 32'd0);
    check("reset miso wrap0", 32'(miso0), 32'd0);
    RESET_N = 1'b1;
    @(negedge SCLK);

    fr = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
    frame("burst write", 6, 0);
    check("burst write image 63:40", 32'(img1[63:40]), 32'h00CCBBAA);

    fr = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("burst read", 6, 0);
    check("burst read byte AA", 32'(got[1][3]), 32'h000000AA);
    check("burst read byte CC", 32'(got[1][5]), 32'h000000CC);

    fr = '{8'h01, 8'h00, 8'hA1, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    frame("wrap write", 5, 0);
    check("wrap1 reg0", 32'(img1[7:0]), 32'h22);
    check("wrap0 reg0", 32'(img0[7:0]), 32'h00);
    check("wrap0 reg161", 32'(img0[161*8 +: 8]), 32'h11);

    fr = '{8'h02, 8'h00, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("wrap read", 7, 0);

    fr = '{8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("flag E1", 1, 0);
    check("flag E1 value", 32'(flags1), 32'b010);
    fr[0] = 8'hFF;
    frame("flag FF", 2, 0);
    check("flag FF value", 32'(flags1), 32'b010);
    fr[0] = 8'hC1;
    frame("flag C1", 1, 0);
    check("flag C1 value", 32'(flags1), 32'b000);

    fr = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("abort 5 bits", 0, 5);
    check("abort ferr set", 32'(ferr1), 32'd1);

    fr = '{8'h7E, 8'h00, 8'h05, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    frame("bad opcode", 5, 0);

    fr = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("oor read", 5, 0);
    check("oor read ferr cleared", 32'(ferr1), 32'd0);

    fr = '{8'h01, 8'h00, 8'h10, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("abort mid data", 3, 5);

    for (int it = 0; it < 12; it++) begin
      sel  = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 4));
      addr = ($urandom_range(0, 1) != 0) ? int'($urandom_range(DEPTH - 4, DEPTH + 2))
                                         : int'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < 8; k++) fr[k] = 8'($urandom);
      fr[1] = 8'(addr >> 8);
      fr[2] = 8'(addr);
      if (sel == 3) begin
        fr[0] = {2'b11, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4))};
        frame($sformatf("rand flag %0d", it), 2, 0);
      end else begin
        fr[0] = (sel == 2) ? 8'h02 : 8'h01;
        frame($sformatf("rand %s %0d", (sel == 2) ? "read" : "write", it), 3 + len, 0);
      end
    end

    fr = '{8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("flag E2", 1, 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge SCLK);
      SS   = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
    end
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check_outputs("midframe reset", 0);
    check("midframe reset miso wrap1", 32'(miso1), 32'd0);
    @(negedge SCLK);
    SS = 1'b1;
    @(negedge SCLK);
    RESET_N = 1'b1;
    @(negedge SCLK);

    fr = '{8'h01, 8'h00, 8'h03, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    frame("post reset write", 5, 0);
    fr = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame("post reset read", 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
